// File: rtl/calc_disp_ctrl.sv
// calc_disp_ctrl: signed value -> BCD (double-dabble, one bit per cycle) ->
// NDIG seven-segment digit codes (0-9 numerals, 4'b1010 blank, 4'b1011 minus).
// Build option: define CALC_DISP_LZB_EN for leading-zero blanking with a
// floating minus sign; otherwise all digits are shown and minus sits in the
// top digit.
module calc_disp_ctrl #(
    parameter int WIDTH = 8,
    parameter int NDIG  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WIDTH-1:0]  value,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [4*NDIG-1:0] digits
);

    localparam int BW = 4 * NDIG;
    localparam int CW = $clog2(WIDTH);
    localparam logic [3:0] DIG_BLANK = 4'b1010;
    localparam logic [3:0] DIG_MINUS = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_FMT  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_start_acc;
    logic            w_conv_last;

    logic [WIDTH-1:0] r_mag;
    logic [BW-1:0]    r_bcd;
    logic             r_sign;
    logic             r_bcd_ovf;
    logic [CW-1:0]    r_cnt;
    logic [BW-1:0]    w_bcd_adj;

    logic [BW-1:0]    w_fmt_digits;
    logic             w_fmt_ovf;

    logic             r_busy;
    logic             r_done;
    logic             r_ovf;
    logic [BW-1:0]    r_digits;

    // Add 3 to every BCD nibble that is 5 or more (pre-shift correction).
    function automatic logic [BW-1:0] dd_adjust(input logic [BW-1:0] bcd);
        logic [BW-1:0] res;
        res = bcd;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                res[4*i +: 4] = bcd[4*i +: 4];
            end
        end
        return res;
    endfunction

    assign w_bcd_adj   = dd_adjust(r_bcd);
    assign w_conv_last = (r_cnt == CW'(WIDTH - 1));

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; start is only honoured in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_CONV;
                    w_start_acc = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CONV: begin
                if (w_conv_last) begin
                    w_state_nxt = S_FMT;
                end else begin
                    w_state_nxt = S_CONV;
                end
            end
            S_FMT:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Conversion datapath: capture sign/magnitude, then one double-dabble step per CONV cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mag     <= '0;
            r_bcd     <= '0;
            r_sign    <= 1'b0;
            r_bcd_ovf <= 1'b0;
            r_cnt     <= '0;
        end else if (w_start_acc) begin
            // Two's-complement negate in WIDTH bits; the most negative value
            // maps to 2^(WIDTH-1), which is correct as an unsigned magnitude.
            r_sign    <= value[WIDTH-1];
            r_mag     <= value[WIDTH-1] ? (~value + WIDTH'(1'b1)) : value;
            r_bcd     <= '0;
            r_bcd_ovf <= 1'b0;
            r_cnt     <= '0;
        end else if (r_state == S_CONV) begin
            r_bcd     <= {w_bcd_adj[BW-2:0], r_mag[WIDTH-1]};
            r_mag     <= {r_mag[WIDTH-2:0], 1'b0};
            r_bcd_ovf <= r_bcd_ovf | w_bcd_adj[BW-1];
            r_cnt     <= r_cnt + CW'(1);
        end else begin
            r_mag     <= r_mag;
            r_bcd     <= r_bcd;
            r_sign    <= r_sign;
            r_bcd_ovf <= r_bcd_ovf;
            r_cnt     <= r_cnt;
        end
    end

`ifdef CALC_DISP_LZB_EN
    localparam int NW = $clog2(NDIG + 1);
    logic [NW-1:0] w_nsig;

    // Formatting with leading-zero blanking and a floating minus sign.
    always_comb begin
        w_nsig       = NW'(1);
        w_fmt_digits = '0;
        w_fmt_ovf    = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (r_bcd[4*i +: 4] != 4'd0) begin
                w_nsig = NW'(i + 1);
            end else begin
                w_nsig = w_nsig;
            end
        end
        for (int i = 0; i < NDIG; i++) begin
            if (NW'(i) < w_nsig) begin
                w_fmt_digits[4*i +: 4] = r_bcd[4*i +: 4];
            end else if (r_sign && (NW'(i) == w_nsig)) begin
                w_fmt_digits[4*i +: 4] = DIG_MINUS;
            end else begin
                w_fmt_digits[4*i +: 4] = DIG_BLANK;
            end
        end
        // No room left for the minus sign counts as overflow.
        w_fmt_ovf = r_bcd_ovf | (r_sign && (w_nsig == NW'(NDIG)));
        if (w_fmt_ovf) begin
            w_fmt_digits = {NDIG{DIG_MINUS}};
        end else begin
            w_fmt_digits = w_fmt_digits;
        end
    end
`else
    // Formatting without blanking: all digits shown, minus fixed in the top digit.
    always_comb begin
        w_fmt_digits = r_bcd;
        w_fmt_ovf    = r_bcd_ovf | (r_sign && (r_bcd[BW-1 -: 4] != 4'd0));
        w_fmt_digits[BW-1 -: 4] = r_sign ? DIG_MINUS : r_bcd[BW-1 -: 4];
        if (w_fmt_ovf) begin
            w_fmt_digits = {NDIG{DIG_MINUS}};
        end else begin
            w_fmt_digits = w_fmt_digits;
        end
    end
`endif

    // Registered outputs: busy tracks non-IDLE, done pulses one cycle after FMT with new digits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            r_digits <= {NDIG{DIG_BLANK}};
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (r_state == S_FMT);
            if (r_state == S_FMT) begin
                r_digits <= w_fmt_digits;
                r_ovf    <= w_fmt_ovf;
            end else begin
                r_digits <= r_digits;
                r_ovf    <= r_ovf;
            end
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign ovf    = r_ovf;
    assign digits = r_digits;

endmodule
